gpo_seg7_display: RTL and testbench
===================================

Name: gpo_seg7_display

Overview:
Consumer side of the SoC general-purpose output port. Latches the factorial result word and status bits that software writes to gpO2/gpO1, and time-multiplexes one 16-bit half of the result onto a 4-digit common-anode seven-segment display. Sits at board level between the system top and the display pins; the gpO1 select and error bits drive sel_i and err_i.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays lit; minimum 2; benches use 4.
LZB, 1, 1 = blank leading zero digits 3..1; digit 0 is never blanked.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
data_i  input  32  result word (gpO2).
sel_i  input  1  half select (gpO1[4]): 0 = bits [15:0], 1 = bits [31:16].
err_i  input  1  factorial error flag (gpO1[0]).
load_i  input  1  single-cycle strobe; captures data_i/sel_i/err_i.
en_i  input  1  display enable.
an_o  output  4  digit anodes, active low; bit k = digit k, digit 0 rightmost.
seg_o  output  7  segments {g,f,e,d,c,b,a}, active low.
dp_o  output  1  decimal point, active low.

Behaviour:
- Reset (rst=1 at edge; overrides all other inputs, including load_i):
  - shadow=16'h0, err_q=0, sel_q=0, div_cnt=0, dig_idx=0.
  - an_o=4'b1111, seg_o=7'b1111111, dp_o=1.
- Load: load_i=1 at an edge captures, in the same cycle:
  - shadow <= sel_i ? data_i[31:16] : data_i[15:0]; sel_q <= sel_i; err_q <= err_i.
  - Does not disturb div_cnt or dig_idx.
  - New content appears on the next output register update (1-cycle latency).
- Refresh:
  - While en_i=1, div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, dig_idx advances 0->1->2->3->0.
  - While en_i=0, div_cnt and dig_idx hold.
- Outputs are registered and recomputed every cycle from the current dig_idx, shadow, err_q and sel_q:
  - en_i=0: an_o=4'b1111, seg_o=7'h7F, dp_o=1.
  - en_i=1: an_o has a 0 only at bit dig_idx. Output latency from a dig_idx change is 1 cycle.
- Digit content (normal, err_q=0): nibble = shadow[4*dig_idx+3 : 4*dig_idx], hex encoded.
  - Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking (LZB=1, err_q=0): digit k (k>=1) shows blank 7'h7F when nibbles k..3 are all zero.
- Error (err_q=1) overrides data: digits 3,2,1,0 show E, r (0101111), r, blank. dp_o stays 1.
- dp_o = 0 only when err_q=0, sel_q=1 and dig_idx=0 (flags upper half); otherwise 1.
- load_i and a refresh wrap on the same edge both take effect; that edge's output update uses the old shadow and old dig_idx.
- Reset mid-scan: display restarts at digit 0 with blank content (shadow=0 shows a single "0" on digit 0 once en_i=1).

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 hex codes, SEG_BLANK, SEG_E and SEG_R;
  - localparam DIGITS=4.
- One sub-module, hex_to_seg7: purely combinational, 4-bit nibble -> 7-bit active-low code.
- Counter, shadow registers, blanking/error mux and output registers stay in gpo_seg7_display.

Test Plan:
1. Reset then en_i=1, REFRESH_DIV=4:
   - an_o walks 1110,1101,1011,0111 with each digit held exactly 4 cycles.
   - seg_o = 1000000 on digit 0, 7'h7F elsewhere (LZB).
2. load_i with data_i=32'h0000_12AF, sel_i=0:
   - Digits 3..0 show 1111001, 0100100, 0001000, 0001110.
   - dp_o=1 throughout.
3. load_i with data_i=32'h00F0_0000, sel_i=1:
   - shadow=16'h00F0; digit 3 blank, digit 2 blank.
   - Digit 1 shows F (0001110), digit 0 shows 0 with dp_o=0.
4. load_i with err_i=1, any data:
   - Digits 3..0 show 0000110, 0101111, 0101111, 1111111.
   - A later load with err_i=0 restores hex content one cycle after the load.
5. Drop en_i mid-scan for 10 cycles:
   - an_o=1111 next cycle.
   - On re-enable, the scan resumes from the held dig_idx/div_cnt.
6. Assert rst on a load_i edge during digit 2:
   - Load is ignored; all outputs take reset values next cycle.
   - After release, scanning restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low {g,f,e,d,c,b,a} codes for hex digits,
// the blank/error glyphs and the digit count of the display.
package seg7_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Index n holds the glyph for nibble value n (listed F down to 0 so index 0 is the LSBs)
  localparam logic [15:0][6:0] HEX_CODES = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_CODES[i_nibble];

endmodule

// File: rtl/gpo_seg7_display.sv
// Latches the software-written result half and status bits, then scans one hex
// digit at a time onto a 4-digit common-anode display with registered outputs.
module gpo_seg7_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZB         = 1'b1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        sel_i,
  input  logic        err_i,
  input  logic        load_i,
  input  logic        en_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [15:0]       r_shadow;
  logic              r_selQ;
  logic              r_errQ;
  logic [CW-1:0]     r_divCnt;
  logic [IW-1:0]     r_digIdx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic [15:0]       w_shifted;
  logic [6:0]        w_hexSeg;
  logic [6:0]        w_digitSeg;
  logic              w_leadZero;
  logic [DIGITS-1:0] w_anSel;
  logic              w_dpN;

  // Shifting the selected digit down to the bottom also tells us whether it and every digit above it are zero
  assign w_shifted  = r_shadow >> {r_digIdx, 2'b00};
  assign w_leadZero = LZB && (r_digIdx != '0) && (w_shifted == 16'h0000);
  assign w_anSel    = ~(DIGITS'(1) << r_digIdx);
  assign w_dpN      = ~(~r_errQ & r_selQ & (r_digIdx == '0));

  hex_to_seg7 u_hexToSeg7 (
    .i_nibble (w_shifted[3:0]),
    .o_seg    (w_hexSeg)
  );

  always_comb begin
    w_digitSeg = SEG_BLANK;
    if (r_errQ) begin
      case (r_digIdx)
        IW'(3):  w_digitSeg = SEG_E;
        IW'(2):  w_digitSeg = SEG_R;
        IW'(1):  w_digitSeg = SEG_R;
        default: w_digitSeg = SEG_BLANK;
      endcase
    end else if (!w_leadZero) begin
      w_digitSeg = w_hexSeg;
    end
  end

  // Load and scan state; a load never touches the scan position
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= 16'h0000;
      r_selQ   <= 1'b0;
      r_errQ   <= 1'b0;
      r_divCnt <= '0;
      r_digIdx <= '0;
    end else begin
      if (load_i) begin
        r_shadow <= sel_i ? data_i[31:16] : data_i[15:0];
        r_selQ   <= sel_i;
        r_errQ   <= err_i;
      end
      if (en_i) begin
        if (r_divCnt == CNT_LAST) begin
          r_divCnt <= '0;
          r_digIdx <= r_digIdx + IW'(1);
        end else begin
          r_divCnt <= r_divCnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_anSel;
      r_seg <= w_digitSeg;
      r_dp  <= w_dpN;
    end
  end

  assign an_o  = r_an;
  assign seg_o = r_seg;
  assign dp_o  = r_dp;

endmodule

// File: tb/tb_gpo_seg7_display.sv
// Directed bench for gpo_seg7_display with a fast refresh divider of 4.
module tb_gpo_seg7_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic        sel_i;
  logic        err_i;
  logic        load_i;
  logic        en_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int errors = 0;
  int checks = 0;
  int edgeN  = 0;

  always #5 clk = ~clk;

  gpo_seg7_display #(.REFRESH_DIV(4), .LZB(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .sel_i  (sel_i),
    .err_i  (err_i),
    .load_i (load_i),
    .en_i   (en_i),
    .an_o   (an_o),
    .seg_o  (seg_o),
    .dp_o   (dp_o)
  );

  // Counts enabled, non-reset edges; the digit shown after edge n is ((n-1)/4)%4
  task automatic tick();
    @(posedge clk);
    if (en_i && !rst) edgeN++;
    #1;
  endtask

  function automatic int curDig();
    return ((edgeN - 1) / 4) % 4;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en_i = 1'b0; load_i = 1'b0; sel_i = 1'b0; err_i = 1'b0; data_i = 32'h0;
    tick(); tick();
    edgeN = 0;
    checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL reset_an: an_o=%b expected 1111", an_o); end
    checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL reset_seg: seg_o=%b expected 1111111", seg_o); end
    checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL reset_dp: dp_o=%b expected 1", dp_o); end
  endtask

  task automatic test_scan_blank();
    rst = 1'b0; en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] expAn;
      logic [6:0] expSeg;
      tick();
      expAn  = ~(4'b0001 << (i / 4));
      expSeg = (i < 4) ? 7'b1000000 : 7'h7F;
      checks++; if (an_o !== expAn) begin errors++; $display("FAIL scan_an[%0d]: an_o=%b expected %b", i, an_o, expAn); end
      checks++; if (seg_o !== expSeg) begin errors++; $display("FAIL scan_seg[%0d]: seg_o=%b expected %b", i, seg_o, expSeg); end
    end
  endtask

  task automatic test_hex_lower();
    logic [6:0] expTab [4];
    expTab[0] = 7'b0001110; expTab[1] = 7'b0001000; expTab[2] = 7'b0100100; expTab[3] = 7'b1111001;
    data_i = 32'h0000_12AF; sel_i = 1'b0; err_i = 1'b0; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int d;
      tick();
      d = curDig();
      checks++; if (an_o !== ~(4'b0001 << d)) begin errors++; $display("FAIL hex_an: an_o=%b digit %0d", an_o, d); end
      checks++; if (seg_o !== expTab[d]) begin errors++; $display("FAIL hex_seg: digit %0d seg_o=%b expected %b", d, seg_o, expTab[d]); end
      checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL hex_dp: digit %0d dp_o=%b expected 1", d, dp_o); end
    end
  endtask

  task automatic test_upper_half();
    logic [6:0] expTab [4];
    expTab[0] = 7'b1000000; expTab[1] = 7'b0001110; expTab[2] = 7'h7F; expTab[3] = 7'h7F;
    data_i = 32'h00F0_0000; sel_i = 1'b1; err_i = 1'b0; load_i = 1'b1;
    tick();
    load_i = 1'b0; sel_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int d;
      logic expDp;
      tick();
      d = curDig();
      expDp = (d == 0) ? 1'b0 : 1'b1;
      checks++; if (seg_o !== expTab[d]) begin errors++; $display("FAIL upper_seg: digit %0d seg_o=%b expected %b", d, seg_o, expTab[d]); end
      checks++; if (dp_o !== expDp) begin errors++; $display("FAIL upper_dp: digit %0d dp_o=%b expected %b", d, dp_o, expDp); end
    end
  endtask

  task automatic test_error();
    logic [6:0] errTab [4];
    logic [6:0] hexTab [4];
    int d;
    errTab[0] = 7'h7F; errTab[1] = 7'b0101111; errTab[2] = 7'b0101111; errTab[3] = 7'b0000110;
    hexTab[0] = 7'b0001110; hexTab[1] = 7'b0001000; hexTab[2] = 7'b0100100; hexTab[3] = 7'b1111001;
    data_i = 32'h1234_5678; sel_i = 1'b1; err_i = 1'b1; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      d = curDig();
      checks++; if (seg_o !== errTab[d]) begin errors++; $display("FAIL err_seg: digit %0d seg_o=%b expected %b", d, seg_o, errTab[d]); end
      checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL err_dp: digit %0d dp_o=%b expected 1", d, dp_o); end
    end
    data_i = 32'h0000_12AF; sel_i = 1'b0; err_i = 1'b0; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    d = curDig();
    checks++; if (seg_o !== errTab[d]) begin errors++; $display("FAIL err_load_edge: digit %0d seg_o=%b expected %b", d, seg_o, errTab[d]); end
    tick();
    d = curDig();
    checks++; if (seg_o !== hexTab[d]) begin errors++; $display("FAIL err_restore: digit %0d seg_o=%b expected %b", d, seg_o, hexTab[d]); end
  endtask

  task automatic test_enable_hold();
    logic [6:0] hexTab [4];
    hexTab[0] = 7'b0001110; hexTab[1] = 7'b0001000; hexTab[2] = 7'b0100100; hexTab[3] = 7'b1111001;
    tick(); tick();
    en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL hold_an[%0d]: an_o=%b expected 1111", i, an_o); end
      checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL hold_seg[%0d]: seg_o=%b expected 1111111", i, seg_o); end
    end
    en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int d;
      tick();
      d = curDig();
      checks++; if (an_o !== ~(4'b0001 << d)) begin errors++; $display("FAIL resume_an: an_o=%b digit %0d", an_o, d); end
      checks++; if (seg_o !== hexTab[d]) begin errors++; $display("FAIL resume_seg: digit %0d seg_o=%b expected %b", d, seg_o, hexTab[d]); end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (curDig() == 2) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_wait: digit 2 not reached, edgeN=%0d", edgeN); end
    rst = 1'b1; load_i = 1'b1; data_i = 32'hFFFF_FFFF; sel_i = 1'b1; err_i = 1'b1;
    tick();
    rst = 1'b0; load_i = 1'b0; sel_i = 1'b0; err_i = 1'b0;
    edgeN = 0;
    checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL midreset_an: an_o=%b expected 1111", an_o); end
    checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL midreset_seg: seg_o=%b expected 1111111", seg_o); end
    checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL midreset_dp: dp_o=%b expected 1", dp_o); end
    for (int i = 0; i < 16; i++) begin
      logic [3:0] expAn;
      logic [6:0] expSeg;
      tick();
      expAn  = ~(4'b0001 << (i / 4));
      expSeg = (i < 4) ? 7'b1000000 : 7'h7F;
      checks++; if (an_o !== expAn) begin errors++; $display("FAIL restart_an[%0d]: an_o=%b expected %b", i, an_o, expAn); end
      checks++; if (seg_o !== expSeg) begin errors++; $display("FAIL restart_seg[%0d]: seg_o=%b expected %b", i, seg_o, expSeg); end
      checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL restart_dp[%0d]: dp_o=%b expected 1", i, dp_o); end
    end
  endtask

  initial begin
    test_reset();
    test_scan_blank();
    test_hex_lower();
    test_upper_half();
    test_error();
    test_enable_hold();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
